// File: rtl/key_debounce_if.sv
// Key front-end bundle: raw key pins in, debounced events and levels out.
interface key_debounce_if #(
  parameter int unsigned KEY_N = 4
);
  logic [KEY_N-1:0] key;          // raw asynchronous key pins
  logic [KEY_N-1:0] key_pulse;    // one-cycle pulse per accepted press
  logic [KEY_N-1:0] key_release;  // one-cycle pulse per accepted release
  logic [KEY_N-1:0] key_long;     // one-cycle pulse at long-press time
  logic [KEY_N-1:0] key_level;    // debounced pressed level

  // Side that owns the pins and consumes the events
  modport master (
    output key,
    input  key_pulse,
    input  key_release,
    input  key_long,
    input  key_level
  );

  // Debouncer side
  modport slave (
    input  key,
    output key_pulse,
    output key_release,
    output key_long,
    output key_level
  );
endinterface

// File: rtl/key_debounce_ctrl.sv
// Multi-key debouncer: two-flop synchroniser plus an independent four-state FSM per key,
// producing registered press/release/long-press pulses and a clean pressed level.
module key_debounce_ctrl #(
  parameter int unsigned KEY_N       = 4,
  parameter int unsigned CLK_HZ      = 12_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input logic         clk,
  input logic         rst,
  key_debounce_if.slave kbus
);

  localparam int unsigned DbCyc   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LongCyc = CLK_HZ / 1000 * LONG_MS;
  localparam int unsigned CntW    = $clog2(LongCyc + 1);

  localparam logic [CntW-1:0] DbLast   = CntW'(DbCyc - 1);
  localparam logic [CntW-1:0] LongLast = CntW'(LongCyc - 1);

  // Pin level when the key is not pressed
  localparam logic IdleLvl = (ACTIVE_LOW != 0);

  // Reject parameter sets that would make the counters meaningless
  if (DbCyc < 2) begin : g_bad_db
    $error("key_debounce_ctrl: debounce window must be at least 2 cycles");
  end
  if (LongCyc <= DbCyc) begin : g_bad_long
    $error("key_debounce_ctrl: long-press time must exceed the debounce window");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPressChk,
    StHeld,
    StRelChk
  } state_e;

  for (genvar i = 0; i < KEY_N; i++) begin : g_key
    logic            sync1_q, sync2_q;
    logic            pressed;
    state_e          state_q, state_d;
    logic [CntW-1:0] db_cnt_q, db_cnt_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic            long_done_q, long_done_d;
    logic            pulse_q, pulse_d;
    logic            release_q, release_d;
    logic            long_q, long_d;
    logic            level_q, level_d;
    logic            db_last;

    assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    assign db_last = (db_cnt_q == DbLast);

    // Next-state and registered-output decode for one key
    always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      long_done_d = long_done_q;
      pulse_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      level_d     = level_q;

      unique case (state_q)
        StIdle: begin
          if (pressed) begin
            state_d  = StPressChk;
            db_cnt_d = '0;
          end
        end

        StPressChk: begin
          if (!pressed) begin
            state_d = StIdle;
          end else if (db_last) begin
            state_d     = StHeld;
            pulse_d     = 1'b1;
            level_d     = 1'b1;
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end

        StHeld, StRelChk: begin
          // Hold time runs through release bounces; saturate at the terminal count
          if (hold_cnt_q != LongLast) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
          // Fire on the edge the counter reaches its terminal value, so key_long lands
          // LongCyc-1 cycles after key_pulse; long_done keeps it to once per press
          if (hold_cnt_d == LongLast && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end

          if (state_q == StHeld) begin
            if (!pressed) begin
              state_d  = StRelChk;
              db_cnt_d = '0;
            end
          end else begin
            if (pressed) begin
              state_d = StHeld;
            end else if (db_last) begin
              state_d   = StIdle;
              release_d = 1'b1;
              level_d   = 1'b0;
            end else begin
              db_cnt_d = db_cnt_q + 1'b1;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end

    // Synchroniser, FSM state, counters and output registers
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q     <= IdleLvl;
        sync2_q     <= IdleLvl;
        state_q     <= StIdle;
        db_cnt_q    <= '0;
        hold_cnt_q  <= '0;
        long_done_q <= 1'b0;
        pulse_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        level_q     <= 1'b0;
      end else begin
        sync1_q     <= kbus.key[i];
        sync2_q     <= sync1_q;
        state_q     <= state_d;
        db_cnt_q    <= db_cnt_d;
        hold_cnt_q  <= hold_cnt_d;
        long_done_q <= long_done_d;
        pulse_q     <= pulse_d;
        release_q   <= release_d;
        long_q      <= long_d;
        level_q     <= level_d;
      end
    end

    assign kbus.key_pulse[i]   = pulse_q;
    assign kbus.key_release[i] = release_q;
    assign kbus.key_long[i]    = long_q;
    assign kbus.key_level[i]   = level_q;
  end

endmodule
